// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 encodings and condition evaluation shared by the execute stage
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  typedef enum logic [3:0] {
    C_YES = 4'h0, C_LE = 4'h1, C_L = 4'h2, C_E = 4'h3,
    C_NE  = 4'h4, C_GE = 4'h5, C_G = 4'h6
  } cond_e;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] BUBBLE_STAT  = S_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic [2:0] CC_RESET     = 3'b100;

  // cc is {ZF,SF,OF}; unused condition codes evaluate false
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational Y86-64 ALU producing result and ZF/SF/OF
module alu64
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   fn_i,
  output logic [W-1:0] res_o,
  output logic         zf_o,
  output logic         sf_o,
  output logic         of_o
);

  logic [W-1:0] sum, diff;

  assign sum  = b_i + a_i;
  assign diff = b_i - a_i;

  always_comb begin
    res_o = '0;
    of_o  = 1'b0;
    case (fn_i)
      ALU_ADD: begin
        res_o = sum;
        of_o  = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      ALU_SUB: begin
        res_o = diff;
        of_o  = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != b_i[W-1]);
      end
      ALU_AND: res_o = b_i & a_i;
      ALU_XOR: res_o = b_i ^ a_i;
      default: res_o = '0;
    endcase
  end

  assign zf_o = (res_o == '0);
  assign sf_o = res_o[W-1];

endmodule

// File: rtl/execute_stage_pipe.sv
// rtl/execute_stage_pipe.sv - Y86-64 execute stage: E register, ALU, CC; optional EXEC_STAT_GATE_EN
module execute_stage_pipe
  import y86_pkg::*;
#(
  parameter int W      = 64,
  parameter int STKINC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         E_bubble,
  input  logic [3:0]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic [3:0]   d_srcA,
  input  logic [3:0]   d_srcB,
  input  logic [3:0]   m_stat,
  input  logic [3:0]   W_stat,
  output logic [3:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valA,
  output logic [3:0]   E_dstM,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic [2:0]   cc_out
);

  localparam logic [W-1:0] STK = W'(STKINC);

  logic [3:0]   stat_q, icode_q, ifun_q, dste_q, dstm_q;
  logic [W-1:0] valc_q, vala_q, valb_q;
  logic [2:0]   cc_q;

  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_fn;
  logic         zf, sf, of, cc_we;

  // Source IDs are consumed upstream for forwarding; execute has no use for them
  logic unused_src;
  assign unused_src = ^{d_srcA, d_srcB};

  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      stat_q  <= BUBBLE_STAT;
      icode_q <= BUBBLE_ICODE;
      ifun_q  <= 4'h0;
      valc_q  <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
    end else begin
      stat_q  <= d_stat;
      icode_q <= d_icode;
      ifun_q  <= d_ifun;
      valc_q  <= d_valC;
      vala_q  <= d_valA;
      valb_q  <= d_valB;
      dste_q  <= d_dstE;
      dstm_q  <= d_dstM;
    end
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode_q)
      I_RRMOVQ:           alu_a = vala_q;
      I_OPQ:              begin alu_a = vala_q; alu_b = valb_q; end
      I_IRMOVQ:           alu_a = valc_q;
      I_RMMOVQ, I_MRMOVQ: begin alu_a = valc_q; alu_b = valb_q; end
      I_CALL, I_PUSHQ:    begin alu_a = '0 - STK; alu_b = valb_q; end
      I_RET, I_POPQ:      begin alu_a = STK; alu_b = valb_q; end
      default:            ;
    endcase
  end

  assign alu_fn = (icode_q == I_OPQ) ? ifun_q : ALU_ADD;

  alu64 #(.W(W)) u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .fn_i  (alu_fn),
    .res_o (e_valE),
    .zf_o  (zf),
    .sf_o  (sf),
    .of_o  (of)
  );

`ifdef EXEC_STAT_GATE_EN
  // Once an older instruction has faulted, younger OPq results must not reach CC
  logic older_exc;
  assign older_exc = (m_stat inside {S_HLT, S_ADR, S_INS}) || (W_stat inside {S_HLT, S_ADR, S_INS});
  assign cc_we = (icode_q == I_OPQ) && (stat_q == S_AOK) && !older_exc;
`else
  logic unused_stat;
  assign unused_stat = ^{m_stat, W_stat};
  assign cc_we = (icode_q == I_OPQ) && (stat_q == S_AOK);
`endif

  always_ff @(posedge clk) begin
    if (rst)        cc_q <= CC_RESET;
    else if (cc_we) cc_q <= {zf, sf, of};
  end

  assign e_Cnd   = cond_eval(ifun_q, cc_q);
  assign e_dstE  = (icode_q == I_RRMOVQ && !e_Cnd) ? RNONE : dste_q;
  assign E_stat  = stat_q;
  assign E_icode = icode_q;
  assign E_ifun  = ifun_q;
  assign E_valA  = vala_q;
  assign E_dstM  = dstm_q;
  assign cc_out  = cc_q;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb/tb_execute_stage_pipe.sv - randomized model-checked bench for execute_stage_pipe
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, E_bubble;
  logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstM, e_dstE;
  logic [63:0] E_valA, e_valE;
  logic        e_Cnd;
  logic [2:0]  cc_out;

  int checks = 0;
  int errors = 0;

  execute_stage_pipe #(.W(64), .STKINC(8)) dut (
    .clk(clk), .rst(rst), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_dstM(E_dstM),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stat, icode, ifun, dstE, dstM;
    logic [63:0] valC, valA, valB;
  } ereg_t;

  ereg_t      me;
  logic [2:0] mcc;
  bit         model_valid = 0;

  // Expected outputs for an instruction sitting in E, from the ISA's definition of each icode
  function automatic void model_e(input ereg_t e, input logic [2:0] cc,
                                  output logic [63:0] v, output logic cnd,
                                  output logic [3:0] dst, output logic [2:0] fl);
    logic signed [64:0] wide;
    logic ovf, zf, sf, of;
    {zf, sf, of} = cc;
    ovf = 1'b0;
    case (e.icode)
      4'h2:       v = e.valA;
      4'h3:       v = e.valC;
      4'h4, 4'h5: v = e.valB + e.valC;
      4'h8, 4'hA: v = e.valB - 64'd8;
      4'h9, 4'hB: v = e.valB + 64'd8;
      4'h6: case (e.ifun)
        4'h0: begin
          wide = $signed({e.valB[63], e.valB}) + $signed({e.valA[63], e.valA});
          v = wide[63:0]; ovf = wide[64] != wide[63];
        end
        4'h1: begin
          wide = $signed({e.valB[63], e.valB}) - $signed({e.valA[63], e.valA});
          v = wide[63:0]; ovf = wide[64] != wide[63];
        end
        4'h2:    v = e.valB & e.valA;
        4'h3:    v = e.valB ^ e.valA;
        default: v = 64'd0;
      endcase
      default: v = 64'd0;
    endcase
    fl = {v == 64'd0, v[63], ovf};
    case (e.ifun)
      4'd0: cnd = 1;
      4'd1: cnd = (sf != of) || zf;
      4'd2: cnd = sf != of;
      4'd3: cnd = zf;
      4'd4: cnd = !zf;
      4'd5: cnd = sf == of;
      4'd6: cnd = (sf == of) && !zf;
      default: cnd = 0;
    endcase
    dst = (e.icode == 4'h2 && !cnd) ? 4'hF : e.dstE;
  endfunction

  function automatic bit is_exc(input logic [3:0] s);
    return s == 4'd2 || s == 4'd3 || s == 4'd4;
  endfunction

  always @(posedge clk) begin
    logic [63:0] v; logic c; logic [3:0] d; logic [2:0] fl; bit gate;
    if (rst) begin
      me = '{stat:4'd1, icode:4'd1, ifun:4'd0, dstE:4'hF, dstM:4'hF, valC:64'd0, valA:64'd0, valB:64'd0};
      mcc = 3'b100;
      model_valid = 1;
    end else begin
      model_e(me, mcc, v, c, d, fl);
`ifdef EXEC_STAT_GATE_EN
      gate = !is_exc(m_stat) && !is_exc(W_stat);
`else
      gate = 1;
`endif
      if (me.icode == 4'h6 && me.stat == 4'd1 && gate) mcc = fl;
      if (E_bubble)
        me = '{stat:4'd1, icode:4'd1, ifun:4'd0, dstE:4'hF, dstM:4'hF, valC:64'd0, valA:64'd0, valB:64'd0};
      else
        me = '{stat:d_stat, icode:d_icode, ifun:d_ifun, dstE:d_dstE, dstM:d_dstM,
               valC:d_valC, valA:d_valA, valB:d_valB};
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] v; logic c; logic [3:0] d; logic [2:0] fl;
    if (model_valid) begin
      model_e(me, mcc, v, c, d, fl);
      check("e_valE", e_valE, v);
      check("e_dstE", {60'd0, e_dstE}, {60'd0, d});
      check("cc_out", {61'd0, cc_out}, {61'd0, mcc});
      check("E_icode", {60'd0, E_icode}, {60'd0, me.icode});
      check("E_stat", {60'd0, E_stat}, {60'd0, me.stat});
      check("E_ifun", {60'd0, E_ifun}, {60'd0, me.ifun});
      check("E_valA", E_valA, me.valA);
      check("E_dstM", {60'd0, E_dstM}, {60'd0, me.dstM});
      if (me.icode == 4'h2 || me.icode == 4'h7)
        check("e_Cnd", {63'd0, e_Cnd}, {63'd0, c});
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [3:0] dste);
    d_stat = 4'd1; d_icode = icode; d_ifun = ifun;
    d_valA = a; d_valB = b; d_valC = c; d_dstE = dste; d_dstM = 4'hF;
    tick();
  endtask

  function automatic logic [63:0] rand64;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {32'd0, $urandom_range(0, 16)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1; E_bubble = 0; m_stat = 4'd1; W_stat = 4'd1;
    d_stat = 4'd1; d_icode = 4'h1; d_ifun = 0; d_valA = 0; d_valB = 0; d_valC = 0;
    d_dstE = 4'hF; d_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    @(negedge clk);
    tick(); tick();
    check("rst_icode", {60'd0, E_icode}, 64'd1);
    check("rst_dstE", {60'd0, e_dstE}, 64'hF);
    check("rst_cc", {61'd0, cc_out}, 64'b100);
    check("rst_valE", e_valE, 64'd0);
    check("rst_cnd", {63'd0, e_Cnd}, 64'd1);
    rst = 0;

    load(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2);
    check("add_ovf_valE", e_valE, 64'h8000_0000_0000_0000);
    load(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2);
    check("add_ovf_cc", {61'd0, cc_out}, 64'b011);
    check("sub_eq_valE", e_valE, 64'd0);
    load(4'h2, 4'h4, 64'd9, 64'd0, 64'd0, 4'h3);
    check("sub_eq_cc", {61'd0, cc_out}, 64'b100);
    check("cmovne_cnd", {63'd0, e_Cnd}, 64'd0);
    check("cmovne_dstE", {60'd0, e_dstE}, 64'hF);
    load(4'h7, 4'h3, 64'd0, 64'd0, 64'h100, 4'hF);
    check("je_cnd", {63'd0, e_Cnd}, 64'd1);
    load(4'h8, 4'h0, 64'd0, 64'h400, 64'h200, 4'h4);
    check("call_valE", e_valE, 64'h3F8);
    load(4'h9, 4'h0, 64'd0, 64'h3F8, 64'd0, 4'h4);
    check("ret_valE", e_valE, 64'h400);
    check("callret_cc", {61'd0, cc_out}, 64'b100);

    E_bubble = 1;
    load(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2);
    E_bubble = 0;
    check("bubble_icode", {60'd0, E_icode}, 64'd1);
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    check("bubble_cc", {61'd0, cc_out}, 64'b100);
    rst = 1; E_bubble = 1;
    load(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    rst = 0; E_bubble = 0;
    check("rstbub_icode", {60'd0, E_icode}, 64'd1);
    check("rstbub_cc", {61'd0, cc_out}, 64'b100);

    m_stat = 4'd3;
    load(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2);
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
`ifdef EXEC_STAT_GATE_EN
    check("gate_cc", {61'd0, cc_out}, 64'b100);
`else
    check("gate_cc", {61'd0, cc_out}, 64'b010);
`endif
    m_stat = 4'd1;

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      E_bubble = ($urandom_range(0, 15) == 0);
      d_stat   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      d_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      d_ifun   = 4'($urandom_range(0, 8));
      d_valA   = rand64(); d_valB = rand64(); d_valC = rand64();
      d_dstE   = 4'($urandom); d_dstM = 4'($urandom);
      d_srcA   = 4'($urandom); d_srcB = 4'($urandom);
      m_stat   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      W_stat   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
